cache_controller_sa: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate cache controller; successor to the direct-mapped controller.

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_if.sv | 27 ++
 rtl/cache_lru.sv | 56 +++++
 rtl/cache_controller_sa.sv | 181 ++++++++++++++++++
 tb/tb_cache_controller_sa.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: FSM states, state_mode encodings and width helpers shared by the set-associative cache
package cache_pkg;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, RESP} state_t;

    localparam logic [1:0] MODE_IDLE       = 2'd0;
    localparam logic [1:0] MODE_HIT        = 2'd1;
    localparam logic [1:0] MODE_MISS_CLEAN = 2'd2;
    localparam logic [1:0] MODE_MISS_DIRTY = 2'd3;

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/cache_if.sv
// cache_if: CPU load/store port and line-wide memory port of the cache controller
interface cache_cpu_if #(parameter int ADDR_W = 32, parameter int WORD_W = 32);
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [WORD_W-1:0] cpu_req_datain;
    logic              cpu_req_rw;
    logic              cpu_req_valid;
    logic              cache_ready;
    logic [WORD_W-1:0] cpu_req_dataout;
    logic              cpu_resp_valid;
    modport master (output cpu_req_addr, cpu_req_datain, cpu_req_rw, cpu_req_valid,
                    input  cache_ready, cpu_req_dataout, cpu_resp_valid);
    modport slave  (input  cpu_req_addr, cpu_req_datain, cpu_req_rw, cpu_req_valid,
                    output cache_ready, cpu_req_dataout, cpu_resp_valid);
endinterface

interface cache_mem_if #(parameter int ADDR_W = 32, parameter int LINE_W = 128);
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_dataout;
    logic [LINE_W-1:0] mem_req_datain;
    logic              mem_req_rw;
    logic              mem_req_valid;
    logic              mem_req_ready;
    modport master (output mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid,
                    input  mem_req_datain, mem_req_ready);
    modport slave  (input  mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid,
                    output mem_req_datain, mem_req_ready);
endinterface

// File: rtl/cache_lru.sv
// cache_lru: per-set age counters, victim selection (first invalid way, else oldest) and update on access
module cache_lru
    import cache_pkg::*;
#(
    parameter int SETS = 1024,
    parameter int WAYS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [$clog2(SETS)-1:0]   idx,
    input  logic [WAYS-1:0]           valid,
    input  logic                      upd,
    input  logic [way_w(WAYS)-1:0]    upd_way,
    output logic [way_w(WAYS)-1:0]    victim
);

    localparam int AW = way_w(WAYS);

    logic [AW-1:0] age [SETS][WAYS];
    logic          found;
    logic [AW-1:0] mx;

    // victim: lowest-index invalid way, otherwise lowest-index way holding the maximum age
    always_comb begin
        victim = '0;
        found  = 1'b0;
        mx     = age[idx][0];
        for (int w = 0; w < WAYS; w++)
            if (!found && !valid[w]) begin
                victim = AW'(w);
                found  = 1'b1;
            end
        if (!found)
            for (int w = 1; w < WAYS; w++)
                if (age[idx][w] > mx) begin
                    mx     = age[idx][w];
                    victim = AW'(w);
                end
    end

    // accessed way becomes youngest; ways not older than it age by one, which also breaks reset ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= '0;
        end else if (upd) begin
            for (int w = 0; w < WAYS; w++)
                if (AW'(w) == upd_way)
                    age[idx][w] <= '0;
                else if (age[idx][w] <= age[idx][upd_way] && age[idx][w] != '1)
                    age[idx][w] <= age[idx][w] + 1'b1;
        end
    end

endmodule

// File: rtl/cache_controller_sa.sv
// cache_controller_sa: N-way set-associative write-back/write-allocate cache; CACHE_PERF_CNT_EN adds hit/miss/writeback counters
module cache_controller_sa
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int WORD_W = 32,
    parameter int SETS   = 1024,
    parameter int WAYS   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    cache_cpu_if.slave  cpu,
    cache_mem_if.master mem,
    output logic [1:0]  state_mode
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt,
    output logic [31:0] perf_wb_cnt
`endif
);

    localparam int OFF_W  = off_w(LINE_W);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W  = way_w(WAYS);
    localparam int BYTE_W = $clog2(WORD_W / 8);
    localparam int WPL    = LINE_W / WORD_W;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_data;
    logic              req_rw, missed, hit, accept, hs, vdirty;
    logic [WAY_W-1:0]  victim, lru_victim, hit_way;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    int                wsel;
    logic [LINE_W-1:0] cur_line, line_wr;

    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAYS-1:0]   dirty_q  [SETS];
    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [LINE_W-1:0] data_mem [SETS][WAYS];

    assign idx      = req_addr[OFF_W +: IDX_W];
    assign tag      = req_addr[ADDR_W-1 -: TAG_W];
    assign wsel     = int'((req_addr >> BYTE_W) % ADDR_W'(WPL));
    assign accept   = cpu.cache_ready && cpu.cpu_req_valid;
    assign hs       = mem.mem_req_valid && mem.mem_req_ready;
    assign vdirty   = valid_q[idx][lru_victim] && dirty_q[idx][lru_victim];
    assign cur_line = data_mem[idx][hit_way];

    cache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
        .clk     (clk),
        .rst_n   (rst_n),
        .idx     (idx),
        .valid   (valid_q[idx]),
        .upd     (state == COMPARE && hit),
        .upd_way (hit_way),
        .victim  (lru_victim)
    );

    // parallel tag match across the valid ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (!hit && valid_q[idx][w] && tag_mem[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
    end

    // store data merged into the hit line at the selected word
    always_comb begin
        line_wr = cur_line;
        line_wr[wsel*WORD_W +: WORD_W] = req_data;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: a refill always returns to COMPARE, which then hits
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, RESP: state_nx = accept ? COMPARE : IDLE;
            COMPARE:    state_nx = hit ? RESP : vdirty ? WRITEBACK : ALLOCATE;
            WRITEBACK:  if (hs) state_nx = ALLOCATE;
            ALLOCATE:   if (hs) state_nx = COMPARE;
            default:    state_nx = IDLE;
        endcase
    end

    // outputs decoded from state; memory request fields are frozen while in WRITEBACK/ALLOCATE
    always_comb begin
        cpu.cache_ready     = state == IDLE || state == RESP;
        cpu.cpu_resp_valid  = state == RESP;
        mem.mem_req_valid   = state == WRITEBACK || state == ALLOCATE;
        mem.mem_req_rw      = state == WRITEBACK;
        mem.mem_req_addr    = state == WRITEBACK ? {tag_mem[idx][victim], idx, {OFF_W{1'b0}}} :
                              state == ALLOCATE  ? {tag, idx, {OFF_W{1'b0}}} : '0;
        mem.mem_req_dataout = state == WRITEBACK ? data_mem[idx][victim] : '0;
    end

    // request latch, victim capture, load data and state_mode (held until the response cycle)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr            <= '0;
            req_data            <= '0;
            req_rw              <= 1'b0;
            missed              <= 1'b0;
            victim              <= '0;
            state_mode          <= MODE_IDLE;
            cpu.cpu_req_dataout <= '0;
        end else begin
            if (accept) begin
                req_addr <= cpu.cpu_req_addr;
                req_data <= cpu.cpu_req_datain;
                req_rw   <= cpu.cpu_req_rw;
                missed   <= 1'b0;
            end
            if (state == COMPARE && hit) begin
                if (!req_rw) cpu.cpu_req_dataout <= cur_line[wsel*WORD_W +: WORD_W];
                if (!missed) state_mode <= MODE_HIT;
            end
            if (state == COMPARE && !hit) begin
                victim     <= lru_victim;
                missed     <= 1'b1;
                state_mode <= vdirty ? MODE_MISS_DIRTY : MODE_MISS_CLEAN;
            end
            if (state == RESP) state_mode <= MODE_IDLE;
        end
    end

    // valid/dirty bits: refill installs a clean line, store hit marks it dirty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            if (state == ALLOCATE && hs) begin
                valid_q[idx][victim] <= 1'b1;
                dirty_q[idx][victim] <= 1'b0;
            end
            if (state == COMPARE && hit && req_rw) dirty_q[idx][hit_way] <= 1'b1;
        end
    end

    // tag/data arrays need no reset: contents are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (state == ALLOCATE && hs) begin
            data_mem[idx][victim] <= mem.mem_req_datain;
            tag_mem[idx][victim]  <= tag;
        end else if (state == COMPARE && hit && req_rw) begin
            data_mem[idx][hit_way] <= line_wr;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    // saturating counters: hits only on first lookup, one miss per request, writebacks on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
            perf_wb_cnt   <= '0;
        end else begin
            if (state == COMPARE && hit && !missed && perf_hit_cnt != '1) perf_hit_cnt <= perf_hit_cnt + 1'b1;
            if (state == COMPARE && !hit && !missed && perf_miss_cnt != '1) perf_miss_cnt <= perf_miss_cnt + 1'b1;
            if (state == WRITEBACK && hs && perf_wb_cnt != '1) perf_wb_cnt <= perf_wb_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller_sa.sv
// tb_cache_controller_sa: vector table plus stall and reset-during-writeback sequences, with a response scoreboard
module tb_cache_controller_sa;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic [1:0]  exp_mode;
        int          exp_lat;
        logic [31:0] exp_wb;
        logic [31:0] exp_rd;
        int          n_mem;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  mode;
        logic        is_read;
        int          lat;
    } exp_t;

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] line;
    } mtx_t;

    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold = 1'b0;
    logic [1:0] state_mode;
    logic [127:0] last_wb = '0;
    exp_t sb[$];
    mtx_t mem_log[$];
    logic [127:0] mm [logic [31:0]];
    int n_cmp = 0;
    int n_err = 0;

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] perf_hit_cnt, perf_miss_cnt, perf_wb_cnt;
`endif

    always #5 clk = ~clk;

    cache_cpu_if cpu_if ();
    cache_mem_if mem_if ();

    cache_controller_sa dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu        (cpu_if),
        .mem        (mem_if),
        .state_mode (state_mode)
`ifdef CACHE_PERF_CNT_EN
        ,
        .perf_hit_cnt  (perf_hit_cnt),
        .perf_miss_cnt (perf_miss_cnt),
        .perf_wb_cnt   (perf_wb_cnt)
`endif
    );

    function automatic logic [31:0] pat(input logic [31:0] a, input int w);
        return {a[15:0] ^ 16'h5A5A, 8'hC0, 8'(w)};
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        if (mm.exists(a)) return mm[a];
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = pat(a, w);
        return l;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // memory model: decides ready on the falling edge, logs the transfer that completes on the next rising edge
    initial begin
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_req_datain = '0;
        forever begin
            @(negedge clk);
            mem_if.mem_req_ready = mem_if.mem_req_valid && !hold;
            if (mem_if.mem_req_ready) begin
                mem_log.push_back('{mem_if.mem_req_rw, mem_if.mem_req_addr, mem_if.mem_req_dataout});
                if (mem_if.mem_req_rw) begin
                    mm[mem_if.mem_req_addr] = mem_if.mem_req_dataout;
                    last_wb = mem_if.mem_req_dataout;
                end else begin
                    mem_if.mem_req_datain = line_of(mem_if.mem_req_addr);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic issue(input logic [31:0] a, input logic rw, input logic [31:0] d);
        int n = 0;
        while (!cpu_if.cache_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", cpu_if.cache_ready, 1);
        cpu_if.cpu_req_addr   = a;
        cpu_if.cpu_req_rw     = rw;
        cpu_if.cpu_req_datain = d;
        cpu_if.cpu_req_valid  = 1'b1;
        @(posedge clk);
        #1 cpu_if.cpu_req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string nm);
        exp_t e;
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_if.cpu_resp_valid && lat < 200);
        chk({nm, "_resp_seen"}, cpu_if.cpu_resp_valid, 1);
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s_scoreboard: got response, want none expected", nm);
            return;
        end
        e = sb.pop_front();
        chk({nm, "_mode"}, state_mode, e.mode);
        if (e.is_read) chk({nm, "_data"}, cpu_if.cpu_req_dataout, e.data);
        if (e.lat > 0) chk({nm, "_latency"}, lat, e.lat);
    endtask

    task automatic apply(input vec_t v, input string nm);
        mem_log.delete();
        sb.push_back('{v.exp_data, v.exp_mode, !v.rw, v.exp_lat});
        issue(v.addr, v.rw, v.wdata);
        wait_resp(nm);
        chk({nm, "_mem_count"}, mem_log.size(), v.n_mem);
        if (v.exp_wb != NONE && mem_log.size() > 0)
            chk({nm, "_wb"}, {mem_log[0].rw, mem_log[0].addr}, {1'b1, v.exp_wb});
        if (v.exp_rd != NONE && mem_log.size() > 0)
            chk({nm, "_refill"}, {mem_log[mem_log.size()-1].rw, mem_log[mem_log.size()-1].addr}, {1'b0, v.exp_rd});
    endtask

    initial begin
        vec_t vt[13];
        vec_t post;
        int n;
        vt[0]  = '{32'h6B00, 1'b0, 32'h0,        pat(32'h6B00, 0), 2'd2, 4, NONE,       32'h6B00, 1};
        vt[1]  = '{32'h6B04, 1'b1, 32'h663322,   32'h0,            2'd1, 2, NONE,       NONE,     0};
        vt[2]  = '{32'h6B04, 1'b0, 32'h0,        32'h663322,       2'd1, 2, NONE,       NONE,     0};
        vt[3]  = '{32'hEB00, 1'b0, 32'h0,        pat(32'hEB00, 0), 2'd2, 4, NONE,       32'hEB00, 1};
        vt[4]  = '{32'h6B00, 1'b0, 32'h0,        pat(32'h6B00, 0), 2'd1, 2, NONE,       NONE,     0};
        vt[5]  = '{32'hAB00, 1'b0, 32'h0,        pat(32'hAB00, 0), 2'd2, 4, NONE,       32'hAB00, 1};
        vt[6]  = '{32'h2B00, 1'b0, 32'h0,        pat(32'h2B00, 0), 2'd3, 5, 32'h6B00,   32'h2B00, 2};
        vt[7]  = '{32'h6B04, 1'b0, 32'h0,        32'h663322,       2'd2, 4, NONE,       32'h6B00, 1};
        vt[8]  = '{32'h2B0C, 1'b1, 32'hDEADBEEF, 32'h0,            2'd1, 2, NONE,       NONE,     0};
        vt[9]  = '{32'h2B0C, 1'b0, 32'h0,        32'hDEADBEEF,     2'd1, 2, NONE,       NONE,     0};
        vt[10] = '{32'h0010, 1'b1, 32'h12345678, 32'h0,            2'd2, 4, NONE,       32'h0010, 1};
        vt[11] = '{32'h0014, 1'b0, 32'h0,        pat(32'h0010, 1), 2'd1, 2, NONE,       NONE,     0};
        vt[12] = '{32'h6B08, 1'b1, 32'hCAFEF00D, 32'h0,            2'd1, 2, NONE,       NONE,     0};
        post   = '{32'h6B00, 1'b0, 32'h0,        pat(32'h6B00, 0), 2'd2, 4, NONE,       32'h6B00, 1};

        cpu_if.cpu_req_addr   = '0;
        cpu_if.cpu_req_datain = '0;
        cpu_if.cpu_req_rw     = 1'b0;
        cpu_if.cpu_req_valid  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cache_ready", cpu_if.cache_ready, 1);
        chk("rst_resp_valid", cpu_if.cpu_resp_valid, 0);
        chk("rst_dataout", cpu_if.cpu_req_dataout, 0);
        chk("rst_mem_valid", mem_if.mem_req_valid, 0);
        chk("rst_mem_rw", mem_if.mem_req_rw, 0);
        chk("rst_mem_addr", mem_if.mem_req_addr, 0);
        chk("rst_mem_dataout", mem_if.mem_req_dataout, 0);
        chk("rst_state_mode", state_mode, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            apply(vt[i], $sformatf("v%0d", i));
`ifdef CACHE_PERF_CNT_EN
            if (i == 6) begin
                chk("perf_hit", perf_hit_cnt, 3);
                chk("perf_miss", perf_miss_cnt, 4);
                chk("perf_wb", perf_wb_cnt, 1);
            end
`endif
        end
        chk("wb_line_word1", last_wb[63:32], 32'h663322);
        chk("wb_line_word0", last_wb[31:0], pat(32'h6B00, 0));

        // refill stalled by memory: request fields frozen, CPU strobes ignored
        mem_log.delete();
        hold = 1'b1;
        sb.push_back('{pat(32'h4000, 0), 2'd2, 1'b1, 0});
        issue(32'h4000, 1'b0, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_if.mem_req_valid && n < 50);
        chk("stall_alloc_req", {mem_if.mem_req_valid, mem_if.mem_req_rw, mem_if.mem_req_addr}, {1'b1, 1'b0, 32'h4000});
        for (int k = 0; k < 5; k++) begin
            cpu_if.cpu_req_addr  = 32'h8000;
            cpu_if.cpu_req_valid = 1'b1;
            @(negedge clk);
            chk("stall_hold", {mem_if.mem_req_valid, mem_if.mem_req_rw, mem_if.mem_req_addr}, {1'b1, 1'b0, 32'h4000});
            chk("stall_cache_ready", cpu_if.cache_ready, 0);
        end
        cpu_if.cpu_req_valid = 1'b0;
        cpu_if.cpu_req_addr  = 32'h4000;
        @(posedge clk);
        #1 hold = 1'b0;
        wait_resp("stall");
        chk("stall_mem_count", mem_log.size(), 1);
        repeat (4) begin
            @(negedge clk);
            chk("strobe_ignored", {cpu_if.cpu_resp_valid, mem_if.mem_req_valid}, 2'b00);
        end

        // reset asserted while a dirty victim is being written back
        mem_log.delete();
        hold = 1'b1;
        issue(32'hEB00, 1'b0, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_if.mem_req_valid && n < 50);
        chk("wb_req", {mem_if.mem_req_valid, mem_if.mem_req_rw, mem_if.mem_req_addr}, {1'b1, 1'b1, 32'h2B00});
        chk("wb_mode", state_mode, 2'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_valid", mem_if.mem_req_valid, 0);
        chk("midrst_cache_ready", cpu_if.cache_ready, 1);
        chk("midrst_state_mode", state_mode, 0);
        chk("midrst_mem_addr", mem_if.mem_req_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hold = 1'b0;
        chk("midrst_no_transfer", mem_log.size(), 0);
        apply(post, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
